// File: rtl/bcd_pkg.sv
// bcd_pkg: shared state encodings, digit limit and digit clamp for the BCD countdown timer.
// No ports; imported by bcd_digit_dec and bcd_down_counter.
package bcd_pkg;
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RUN     = 2'd1;
   localparam logic [1:0] ST_PAUSE   = 2'd2;
   localparam logic [1:0] ST_EXPIRED = 2'd3;
   localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
   function automatic logic [3:0] clamp_digit(input logic [3:0] d);
      return (d > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : d;
   endfunction
endpackage

// File: rtl/bcd_digit_dec.sv
// bcd_digit_dec: next-value logic for one BCD digit counting down, wrapping 0 -> 9.
// Ports: en (tick enable), bin (borrow in), digit (current digit),
//        nxt (digit after this cycle), bout (borrow out, digit wrapped from 0).
module bcd_digit_dec
   import bcd_pkg::*;
(
   input  logic       en,
   input  logic       bin,
   input  logic [3:0] digit,
   output logic [3:0] nxt,
   output logic       bout
);
   logic act;
   assign act  = en & bin;
   assign bout = act & (digit == 4'd0);
   assign nxt  = act ? ((digit == 4'd0) ? BCD_MAX_DIGIT : digit - 4'd1) : digit;
endmodule

// File: rtl/bcd_down_counter.sv
// bcd_down_counter: two-digit BCD countdown timer with preset load, pause/resume and expiry borrow.
// Ports: clk_i, rst_ni (async active-low); load_i + load_tens_i/load_ones_i preset;
//        start_i, stop_i, decrement_i (tick strobe); count_tens_o/count_ones_o digits,
//        count_o binary value, running_o, expired_o, borrow_o (combinational expiry pulse).
module bcd_down_counter
   import bcd_pkg::*;
#(
   parameter int MAX_COUNT   = 99,
   parameter int AUTO_RELOAD = 0
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       load_i,
   input  logic [3:0] load_tens_i,
   input  logic [3:0] load_ones_i,
   input  logic       start_i,
   input  logic       stop_i,
   input  logic       decrement_i,
   output logic [3:0] count_tens_o,
   output logic [3:0] count_ones_o,
   output logic [6:0] count_o,
   output logic       running_o,
   output logic       expired_o,
   output logic       borrow_o
);
   localparam logic [6:0] MAX_V = 7'(MAX_COUNT);
   localparam logic [3:0] MAX_T = 4'(MAX_COUNT / 10);
   localparam logic [3:0] MAX_O = 4'(MAX_COUNT % 10);
   logic [1:0] state;
   logic [3:0] tens, ones, pre_tens, pre_ones;
   logic [3:0] tens_nx, ones_nx, lt, lo, ld_tens, ld_ones;
   logic [6:0] lv;
   logic       tick, ones_b, zero;
   assign lt      = clamp_digit(load_tens_i);
   assign lo      = clamp_digit(load_ones_i);
   assign lv      = {3'b0, lt} * 7'd10 + {3'b0, lo};
   assign ld_tens = (lv > MAX_V) ? MAX_T : lt;
   assign ld_ones = (lv > MAX_V) ? MAX_O : lo;
   assign zero    = (tens == 4'd0) && (ones == 4'd0);
   // tick covers the 00 case too: the tens borrow-out then is exactly the expiry borrow
   assign tick    = (state == ST_RUN) & decrement_i & ~load_i & ~stop_i;
   bcd_digit_dec u_ones (
      .en    (tick),
      .bin   (1'b1),
      .digit (ones),
      .nxt   (ones_nx),
      .bout  (ones_b)
   );
   bcd_digit_dec u_tens (
      .en    (tick),
      .bin   (ones_b),
      .digit (tens),
      .nxt   (tens_nx),
      .bout  (borrow_o)
   );
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= ST_IDLE;
         tens     <= 4'd0;
         ones     <= 4'd0;
         pre_tens <= 4'd0;
         pre_ones <= 4'd0;
      end else if (load_i) begin
         state    <= ST_IDLE;
         tens     <= ld_tens;
         ones     <= ld_ones;
         pre_tens <= ld_tens;
         pre_ones <= ld_ones;
      end else begin
         case (state)
            ST_IDLE:  if (start_i && !zero) state <= ST_RUN;
            ST_RUN: begin
               if (stop_i) state <= ST_PAUSE;
               else if (borrow_o) begin
                  if (AUTO_RELOAD != 0) begin
                     tens <= pre_tens;
                     ones <= pre_ones;
                  end else state <= ST_EXPIRED;
               end else begin
                  tens <= tens_nx;
                  ones <= ones_nx;
               end
            end
            ST_PAUSE: if (start_i) state <= ST_RUN;
            default:  state <= ST_EXPIRED;
         endcase
      end
   end
   assign count_tens_o = tens;
   assign count_ones_o = ones;
   assign count_o      = {3'b0, tens} * 7'd10 + {3'b0, ones};
   assign running_o    = (state == ST_RUN);
   assign expired_o    = (state == ST_EXPIRED);
endmodule
